// File: rtl/frame_loader.sv
// Packs SPI bytes into pixels, writes them row-major into the back buffer,
// flips buffers on frame boundaries. Option: FRAME_LOADER_LENGTH_CHECK_EN.
module frame_loader #(
  parameter int rows    = 8,
  parameter int columns = 32,
  parameter int width   = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 data,
  input  logic                       valid,
  input  logic                       sot,
  input  logic                       eot,
  input  logic                       frame_complete,
  output logic                       wen,
  output logic [$clog2(rows)-1:0]    wrow,
  output logic [$clog2(columns)-1:0] wcol,
  output logic [width-1:0]           wdata,
  output logic                       flip,
  output logic                       busy,
  output logic                       error
);

  localparam int BPP   = width / 8;
  localparam int TOTAL = rows * columns;
  localparam int RW    = $clog2(rows);
  localparam int CW    = $clog2(columns);
  localparam int PW    = $clog2(TOTAL + 1);
  localparam int BW    = (BPP > 1) ? $clog2(BPP) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLIP_WAIT
  } state_t;

  state_t state, state_nx;

  logic [BW-1:0]    byte_cnt, bc_e, bc_nx;
  logic [PW-1:0]    pix_cnt, pc_e, pc_nx;
  logic [RW-1:0]    row, row_e, row_nx;
  logic [CW-1:0]    col, col_e, col_nx;
  logic [width-1:0] shreg, sh_nx;
  logic             take, last;

  // sot in LOAD restarts: the same-cycle byte sees cleared counters
  always_comb begin
    bc_e   = sot ? '0 : byte_cnt;
    pc_e   = sot ? '0 : pix_cnt;
    row_e  = sot ? '0 : row;
    col_e  = sot ? '0 : col;
    sh_nx  = (shreg << 8) | width'(data);
    take   = (state == LOAD) && valid &&
             (pc_e != PW'(TOTAL));
    last   = take && (bc_e == BW'(BPP - 1));
    bc_nx  = bc_e;
    pc_nx  = pc_e;
    row_nx = row_e;
    col_nx = col_e;
    if (last) begin
      bc_nx = '0;
      pc_nx = pc_e + PW'(1);
      if (col_e == CW'(columns - 1)) begin
        col_nx = '0;
        row_nx = row_e + RW'(1);
      end else begin
        col_nx = col_e + CW'(1);
      end
    end else if (take) begin
      bc_nx = bc_e + BW'(1);
    end
  end

`ifdef FRAME_LOADER_LENGTH_CHECK_EN
  logic ok;
  assign ok = (pc_nx == PW'(TOTAL)) && (bc_nx == '0);
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (sot) state_nx = LOAD;
      LOAD:
        if (!sot && eot) begin
`ifdef FRAME_LOADER_LENGTH_CHECK_EN
          state_nx = ok ? FLIP_WAIT : IDLE;
`else
          state_nx = FLIP_WAIT;
`endif
        end
      FLIP_WAIT:
        if (frame_complete) state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      pix_cnt  <= '0;
      row      <= '0;
      col      <= '0;
      shreg    <= '0;
      wen      <= 1'b0;
      wrow     <= '0;
      wcol     <= '0;
      wdata    <= '0;
      flip     <= 1'b0;
    end else begin
      wen <= 1'b0;
      if (state == IDLE && sot) begin
        byte_cnt <= '0;
        pix_cnt  <= '0;
        row      <= '0;
        col      <= '0;
      end else if (state == LOAD) begin
        byte_cnt <= bc_nx;
        pix_cnt  <= pc_nx;
        row      <= row_nx;
        col      <= col_nx;
        if (take) shreg <= sh_nx;
        if (last) begin
          wen   <= 1'b1;
          wrow  <= row_e;
          wcol  <= col_e;
          wdata <= sh_nx;
        end
      end
      if (state == FLIP_WAIT && frame_complete)
        flip <= ~flip;
    end
  end

`ifdef FRAME_LOADER_LENGTH_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) error <= 1'b0;
    else     error <= (state == LOAD) && !sot && eot && !ok;
  end
`else
  assign error = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_frame_loader.sv
// Bench for frame_loader: table of frame lengths, random frames,
// hand sequences for restart, FLIP_WAIT and async reset.
module tb_frame_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data;
  logic        valid, sot, eot, fc;
  logic        wen, flip, busy, error;
  logic [2:0]  wrow;
  logic [4:0]  wcol;
  logic [23:0] wdata;

  frame_loader dut (
    .clk(clk), .rst(rst), .data(data), .valid(valid),
    .sot(sot), .eot(eot), .frame_complete(fc),
    .wen(wen), .wrow(wrow), .wcol(wcol), .wdata(wdata),
    .flip(flip), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  r;
    logic [4:0]  c;
    logic [23:0] d;
  } wr_t;

  typedef struct {
    int n;
    int ew;
    bit ee;
    bit tog;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   nwr    = 0;
  bit   exp_flip = 1'b0;
  bit   chk_en;
  wr_t  exp_q[$];
  logic [7:0] fb[$];
  wr_t  me;
  vec_t tbl[6];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // every write is compared against the model's next expected pixel
  always @(negedge clk) begin
    if (wen === 1'b1) begin
      nwr++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: row %0d col %0d data %h expected none",
                 wrow, wcol, wdata);
      end else begin
        me = exp_q.pop_front();
        if ({wrow, wcol, wdata} !== {me.r, me.c, me.d}) begin
          errors++;
          $display("FAIL write: got r%0d c%0d %h expected r%0d c%0d %h",
                   wrow, wcol, wdata, me.r, me.c, me.d);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_frame();
    fb.delete();
  endtask

  // model: pixel i = bytes 3i..3i+2, at row i/32 col i%32, only i < 256
  task automatic put_byte(input logic [7:0] b);
    int i;
    fb.push_back(b);
    if (fb.size() % 3 == 0) begin
      i = fb.size() / 3 - 1;
      if (i < 256)
        exp_q.push_back('{r: 3'(i / 32), c: 5'(i % 32),
                          d: {fb[3*i], fb[3*i+1], fb[3*i+2]}});
    end
  endtask

  task automatic send_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      valid = 1'b1;
      data  = 8'($urandom);
      put_byte(data);
      step();
      valid = 1'b0;
    end
  endtask

  task automatic pulse_fc();
    repeat ($urandom_range(0, 3)) step();
    fc = 1'b1;
    step();
    fc = 1'b0;
    exp_flip = ~exp_flip;
    check("flip_toggle", 32'(flip), 32'(exp_flip));
    check("busy_fall", 32'(busy), 32'd0);
  endtask

  task automatic run_frame(input int n, input int ew,
                           input bit ee, input bit tog);
    int n0;
    n0 = nwr;
    new_frame();
    sot = 1'b1;
    step();
    sot = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
    send_bytes(n);
    eot = 1'b1;
    step();
    eot = 1'b0;
    check("error", 32'(error), 32'(ee));
    check("write_count", 32'(nwr - n0), 32'(ew));
    check("writes_pending", 32'(exp_q.size()), 32'd0);
    if (tog) begin
      check("busy_flipwait", 32'(busy), 32'd1);
      check("flip_hold", 32'(flip), 32'(exp_flip));
      pulse_fc();
    end else begin
      check("busy_idle", 32'(busy), 32'd0);
      check("flip_keep", 32'(flip), 32'(exp_flip));
      step();
      check("error_pulse_end", 32'(error), 32'd0);
    end
  endtask

  initial begin
    int n, ew, n0;
    bit ee;
`ifdef FRAME_LOADER_LENGTH_CHECK_EN
    chk_en = 1'b1;
`else
    chk_en = 1'b0;
`endif
    rst = 1'b1; data = '0; valid = 0; sot = 0; eot = 0; fc = 0;
    #1;
    check("rst_wen",   32'(wen),   32'd0);
    check("rst_wrow",  32'(wrow),  32'd0);
    check("rst_wcol",  32'(wcol),  32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_flip",  32'(flip),  32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_error", 32'(error), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    tbl[0] = '{n: 768, ew: 256, ee: 1'b0,   tog: 1'b1};
    tbl[1] = '{n: 99,  ew: 33,  ee: chk_en, tog: !chk_en};
    tbl[2] = '{n: 100, ew: 33,  ee: chk_en, tog: !chk_en};
    tbl[3] = '{n: 3,   ew: 1,   ee: chk_en, tog: !chk_en};
    tbl[4] = '{n: 800, ew: 256, ee: 1'b0,   tog: 1'b1};
    tbl[5] = '{n: 0,   ew: 0,   ee: chk_en, tog: !chk_en};
    for (int i = 0; i < 6; i++)
      run_frame(tbl[i].n, tbl[i].ew, tbl[i].ee, tbl[i].tog);

    repeat (4) begin
      n  = $urandom_range(0, 900);
      ew = (n / 3 > 256) ? 256 : n / 3;
      ee = chk_en && (n < 768);
      run_frame(n, ew, ee, !ee);
    end

    // restart with sot+valid together; last byte coincides with eot
    n0 = nwr;
    new_frame();
    sot = 1'b1;
    step();
    sot = 1'b0;
    send_bytes(10);
    sot = 1'b1; valid = 1'b1; data = 8'($urandom);
    new_frame();
    put_byte(data);
    step();
    sot = 1'b0; valid = 1'b0;
    send_bytes(766);
    valid = 1'b1; eot = 1'b1; data = 8'($urandom);
    put_byte(data);
    step();
    valid = 1'b0; eot = 1'b0;
    step();
    check("restart_writes", 32'(nwr - n0), 32'd259);
    check("restart_error", 32'(error), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    pulse_fc();

    // overflow; fc with eot ignored; FLIP_WAIT drops sot/valid
    n0 = nwr;
    new_frame();
    sot = 1'b1;
    step();
    sot = 1'b0;
    send_bytes(800);
    eot = 1'b1; fc = 1'b1;
    step();
    eot = 1'b0; fc = 1'b0;
    check("ovf_writes", 32'(nwr - n0), 32'd256);
    check("fc_eot_busy", 32'(busy), 32'd1);
    check("fc_eot_flip", 32'(flip), 32'(exp_flip));
    repeat (3) begin
      sot = 1'b1; valid = 1'b1; data = 8'($urandom);
      step();
    end
    sot = 1'b0; valid = 1'b0;
    step();
    step();
    check("fw_no_writes", 32'(nwr - n0), 32'd256);
    check("fw_busy", 32'(busy), 32'd1);
    pulse_fc();

    // async reset mid-LOAD with flip high
    if (!exp_flip) run_frame(768, 256, 1'b0, 1'b1);
    check("pre_rst_flip", 32'(flip), 32'd1);
    new_frame();
    sot = 1'b1;
    step();
    sot = 1'b0;
    send_bytes(50);
    rst = 1'b1;
    #1;
    check("arst_flip",  32'(flip),  32'd0);
    check("arst_busy",  32'(busy),  32'd0);
    check("arst_wen",   32'(wen),   32'd0);
    check("arst_wrow",  32'(wrow),  32'd0);
    check("arst_wcol",  32'(wcol),  32'd0);
    check("arst_wdata", 32'(wdata), 32'd0);
    check("arst_error", 32'(error), 32'd0);
    exp_q.delete();
    new_frame();
    exp_flip = 1'b0;
    step();
    rst = 1'b0;
    step();
    run_frame(768, 256, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_loader.md
# frame_loader

Assembles the byte stream from the SPI slave into 24-bit pixels and writes them into the back buffer of `display_memory` in row-major order. At end of transfer it waits for the display driver's `frame_complete` and then toggles `flip`, so buffer swaps happen only on frame boundaries. Sits between `spi_slave` (upstream) and `display_memory` / `display_driver` (downstream) in `top`.

## Interface
- `rows`, 8, panel rows per segment
- `columns`, 32, panel columns
- `width`, 24, pixel width in bits; must be a multiple of 8; bytes per pixel BPP = width/8
- `clk`  input  1  display clock
- `rst`  input  1  reset; asynchronous and active-high
- `data`  input  8  received byte, qualified by `valid`
- `valid`  input  1  one-cycle strobe: `data` holds a byte
- `sot`  input  1  one-cycle strobe: start of transfer (slave select asserted)
- `eot`  input  1  one-cycle strobe: end of transfer (slave select released)
- `frame_complete`  input  1  one-cycle strobe from `display_driver` at end of scan
- `wen`  output  1  memory write enable, one-cycle pulse
- `wrow`  output  $clog2(rows)  write row
- `wcol`  output  $clog2(columns)  write column
- `wdata`  output  width  pixel, first received byte in MSBs
- `flip`  output  1  buffer select level to `display_memory`; toggles per accepted frame
- `busy`  output  1  high in LOAD and FLIP_WAIT
- `error`  output  1  one-cycle pulse on rejected frame (see Configuration)

## Operation
- States: IDLE, LOAD, FLIP_WAIT.
- IDLE: `sot` → LOAD; clear byte count, pixel count, row=0, col=0. `valid`, `eot`, `frame_complete` ignored.
- LOAD, per `valid`: shift `data` into assembly register (MSB first), increment byte count. On BPP-th byte: present pixel on `wdata`, current row/col on `wrow`/`wcol`, pulse `wen`; then advance col; col==columns-1 wraps to 0 and increments row. After rows*columns pixels stored, further bytes discarded (no `wen`, counters frozen).
- LOAD, `sot`: restart — counters cleared, no flip, state stays LOAD.
- LOAD, `eot`: partial pixel discarded; → FLIP_WAIT (subject to Configuration).
- Same-cycle `valid` and `eot`: byte processed first, then `eot`. Same-cycle `sot` and `valid`: counters cleared, byte taken as first byte of new frame.
- FLIP_WAIT: `frame_complete` → toggle `flip`, → IDLE. `sot` and `valid` ignored (data lost; upstream must respect `busy`).
- `frame_complete` in the same cycle as the `eot` that enters FLIP_WAIT does not count; next strobe is used.
- Unwritten pixels of a short frame keep previous back-buffer contents.

## Timing
- Reset values: state IDLE, `wen`=0, `wrow`=0, `wcol`=0, `wdata`=0, `flip`=0, `busy`=0, `error`=0.
- `wen` asserted the cycle after the `valid` carrying the last byte of a pixel; `wrow`/`wcol`/`wdata` registered and stable in that cycle.
- `flip` toggles the cycle after the counted `frame_complete`; `busy` falls in the same cycle.
- `busy` rises the cycle after `sot`.
- `rst` mid-frame: immediate return to reset values; `flip` returns to 0 regardless of prior value.
- Back-to-back `valid` every cycle supported; full pixel throughput one per BPP cycles.

## Configuration
- `FRAME_LOADER_LENGTH_CHECK_EN` defined: on `eot` in LOAD, if pixel count ≠ rows*columns or a partial pixel is pending, pulse `error` (cycle after `eot`), → IDLE, no flip. Exact-length frames proceed to FLIP_WAIT.
- Not defined: any `eot` in LOAD → FLIP_WAIT; `error` tied 0.

## Test plan
- Full frame: `sot`, 768 bytes (8×32×3), `eot`, then `frame_complete` → 256 `wen` pulses, first at row0/col0 with `wdata`=first three bytes, last at row7/col31; `flip` 0→1 after `frame_complete`.
- Column/row wrap: 33 pixels → 33rd write at `wrow`=1, `wcol`=0.
- Short frame (100 bytes, `eot`): with macro → 33 writes, `error` pulse, `flip` unchanged; without → 33 writes, `flip` toggles on next `frame_complete`.
- Restart: `sot`, 10 bytes, `sot`, full 768 bytes, `eot` → writes restart at row0/col0; exactly one flip.
- Overflow and FLIP_WAIT: 800 bytes → 256 writes only; during FLIP_WAIT `sot`/`valid` produce no `wen`; `frame_complete` coincident with `eot` ignored, next toggles `flip`.
- Async `rst` asserted mid-LOAD with `flip`=1 → all outputs at reset values immediately, `flip`=0.
